// File: rtl/inst_mem_pipelined_pkg.sv
// Shared definitions for the pipelined instruction memory: FSM encoding,
// idle/fault instruction constant and the word-index width helper.
package inst_mem_pipelined_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction word storage: synchronous write, asynchronous read.
// Optional per-word even parity when INST_MEM_PARITY_EN is defined.
module inst_mem_array
  import inst_mem_pipelined_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 128,
  parameter int                    AW         = idx_width(DEPTH),
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
`ifdef INST_MEM_PARITY_EN
  input  logic                  parity_flip_i,
`endif
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  perr_o
);

  // Words are stored XORed with NOP_WORD so the all-zero power-up state
  // reads back as NOP_WORD without needing a memory initialiser.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i ^ NOP_WORD;
  end

  assign rdata_o = mem_q[raddr_i] ^ NOP_WORD;

`ifdef INST_MEM_PARITY_EN
  // Stored bit is the even parity of the word, folded with parity(NOP_WORD)
  // so a zero power-up bit is consistent with the NOP_WORD contents.
  logic par_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) par_q[waddr_i] <= (^wdata_i) ^ (^NOP_WORD) ^ parity_flip_i;
  end

  assign perr_o = (^rdata_o) ^ (^NOP_WORD) ^ par_q[raddr_i];
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/inst_mem_pipelined.sv
// Pipelined instruction memory: valid/ready fetch with LATENCY-cycle response,
// fault decode, flush and run-time load port. Parity via INST_MEM_PARITY_EN.
module inst_mem_pipelined
  import inst_mem_pipelined_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 128,
  parameter int                    LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          ReqValid,
  output logic                          ReqReady,
  input  logic [31:0]                   ReqAddr,
  output logic                          RspValid,
  input  logic                          RspReady,
  output logic [DATA_WIDTH-1:0]         RspInst,
  output logic                          RspFault,
  input  logic                          Flush,
  input  logic                          LoadEn,
  input  logic [idx_width(DEPTH)-1:0]   LoadAddr,
`ifdef INST_MEM_PARITY_EN
  input  logic                          LoadParityFlip,
`endif
  input  logic [DATA_WIDTH-1:0]         LoadData
);

  localparam int AW = idx_width(DEPTH);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  fault_q, fault_d;

  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_perr;
  logic                  req_fault;
  logic                  req_ready;
  logic                  accept;

  assign rd_idx = ReqAddr[AW+1:2];

  inst_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .NOP_WORD   (NOP_WORD)
  ) u_array (
    .clk_i         (Clk),
    .we_i          (LoadEn),
    .waddr_i       (LoadAddr),
    .wdata_i       (LoadData),
`ifdef INST_MEM_PARITY_EN
    .parity_flip_i (LoadParityFlip),
`endif
    .raddr_i       (rd_idx),
    .rdata_o       (rd_data),
    .perr_o        (rd_perr)
  );

  assign req_fault = (ReqAddr[1:0] != 2'b00) || (|ReqAddr[31:AW+2]) || rd_perr;

  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = RspReady;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = ReqValid && req_ready && !Flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      inst_d  = NOP_WORD;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RESP;
        end
        RESP: if (RspReady) state_d = IDLE;
        default: ;
      endcase
      // Accept overrides the RESP->IDLE move so back-to-back fetches have no gap.
      if (accept) begin
        inst_d  = req_fault ? NOP_WORD : rd_data;
        fault_d = req_fault;
        state_d = (LATENCY == 1) ? RESP : WAIT;
        cnt_d   = 2'(LATENCY - 1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      inst_q  <= NOP_WORD;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  assign ReqReady = req_ready;
  assign RspValid = (state_q == RESP);
  assign RspInst  = (state_q == RESP) ? inst_q : NOP_WORD;
  assign RspFault = (state_q == RESP) && fault_q;

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Directed bench for inst_mem_pipelined: one LATENCY=1 and one LATENCY=3
// instance sharing clock, reset, load port, address, RspReady and Flush.
module tb_inst_mem_pipelined;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ReqAddr;
  logic        RspReady;
  logic        Flush;
  logic        LoadEn;
  logic [6:0]  LoadAddr;
  logic [31:0] LoadData;
  logic        LoadParityFlip;

  logic        rv1, rdy1, val1, flt1;
  logic [31:0] inst1;
  logic        rv3, rdy3, val3, flt3;
  logic [31:0] inst3;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  inst_mem_pipelined #(.DATA_WIDTH(32), .DEPTH(128), .LATENCY(1), .NOP_WORD(32'h0)) u_l1 (
    .Clk(Clk), .Reset(Reset), .ReqValid(rv1), .ReqReady(rdy1), .ReqAddr(ReqAddr),
    .RspValid(val1), .RspReady(RspReady), .RspInst(inst1), .RspFault(flt1),
    .Flush(Flush), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
`ifdef INST_MEM_PARITY_EN
    .LoadParityFlip(LoadParityFlip),
`endif
    .LoadData(LoadData)
  );

  inst_mem_pipelined #(.DATA_WIDTH(32), .DEPTH(128), .LATENCY(3), .NOP_WORD(32'h0)) u_l3 (
    .Clk(Clk), .Reset(Reset), .ReqValid(rv3), .ReqReady(rdy3), .ReqAddr(ReqAddr),
    .RspValid(val3), .RspReady(RspReady), .RspInst(inst3), .RspFault(flt3),
    .Flush(Flush), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
`ifdef INST_MEM_PARITY_EN
    .LoadParityFlip(LoadParityFlip),
`endif
    .LoadData(LoadData)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [6:0] a, input logic [31:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    step();
    LoadEn = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ReqAddr = 32'h0; RspReady = 1'b0; Flush = 1'b0;
    LoadEn = 1'b0; LoadAddr = 7'd0; LoadData = 32'h0; LoadParityFlip = 1'b0;
    rv1 = 1'b0; rv3 = 1'b0;
    step(); step();
    chk("rst_valid", {31'b0, val1}, 32'd0);
    chk("rst_inst", inst1, 32'h0);
    chk("rst_fault", {31'b0, flt1}, 32'd0);
    chk("rst_ready", {31'b0, rdy1}, 32'd1);
    Reset = 1'b0;
    step();

    load(7'd0, 32'h2010_0001);
    load(7'd1, 32'h2011_0001);
    load(7'd2, 32'hDEAD_BEEF);

    // LATENCY=1 back-to-back fetches
    ReqAddr = 32'h0; rv1 = 1'b1; RspReady = 1'b1;
    #1 chk("l1_ready_idle", {31'b0, rdy1}, 32'd1);
    step();
    chk("l1_valid0", {31'b0, val1}, 32'd1);
    chk("l1_inst0", inst1, 32'h2010_0001);
    chk("l1_fault0", {31'b0, flt1}, 32'd0);
    ReqAddr = 32'h4;
    #1 chk("l1_ready_b2b", {31'b0, rdy1}, 32'd1);
    step();
    chk("l1_valid1", {31'b0, val1}, 32'd1);
    chk("l1_inst1", inst1, 32'h2011_0001);
    rv1 = 1'b0;
    step();
    chk("l1_idle_valid", {31'b0, val1}, 32'd0);
    chk("l1_idle_inst", inst1, 32'h0);

    // LATENCY=3 timing
    ReqAddr = 32'h8; rv3 = 1'b1;
    step();
    rv3 = 1'b0;
    chk("l3_wait1_valid", {31'b0, val3}, 32'd0);
    chk("l3_wait1_ready", {31'b0, rdy3}, 32'd0);
    step();
    chk("l3_wait2_valid", {31'b0, val3}, 32'd0);
    chk("l3_wait2_ready", {31'b0, rdy3}, 32'd0);
    step();
    chk("l3_resp_valid", {31'b0, val3}, 32'd1);
    chk("l3_resp_inst", inst3, 32'hDEAD_BEEF);
    step();
    chk("l3_done_valid", {31'b0, val3}, 32'd0);

    // faults
    ReqAddr = 32'h6; rv1 = 1'b1;
    step();
    chk("misalign_fault", {31'b0, flt1}, 32'd1);
    chk("misalign_inst", inst1, 32'h0);
    ReqAddr = 32'h200;
    step();
    chk("oor_valid", {31'b0, val1}, 32'd1);
    chk("oor_fault", {31'b0, flt1}, 32'd1);
    chk("oor_inst", inst1, 32'h0);
    rv1 = 1'b0;
    step();

    // response held with RspReady low; load to same word mid-hold
    RspReady = 1'b0; ReqAddr = 32'h4; rv1 = 1'b1;
    step();
    rv1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        LoadEn = 1'b1; LoadAddr = 7'd1; LoadData = 32'hCAFE_F00D;
      end
      #1;
      chk("hold_valid", {31'b0, val1}, 32'd1);
      chk("hold_inst", inst1, 32'h2011_0001);
      chk("hold_ready", {31'b0, rdy1}, 32'd0);
      step();
      LoadEn = 1'b0;
    end
    chk("hold_after_inst", inst1, 32'h2011_0001);
    RspReady = 1'b1;
    step();
    chk("hold_taken", {31'b0, val1}, 32'd0);

    // read-before-write on simultaneous load and accept
    ReqAddr = 32'h4; rv1 = 1'b1;
    LoadEn = 1'b1; LoadAddr = 7'd1; LoadData = 32'h1234_5678;
    step();
    LoadEn = 1'b0;
    chk("rbw_old", inst1, 32'hCAFE_F00D);
    step();
    chk("rbw_new", inst1, 32'h1234_5678);
    rv1 = 1'b0;
    step();

    // flush in WAIT; request presented in flush cycle must be dropped
    RspReady = 1'b0; ReqAddr = 32'h8; rv3 = 1'b1;
    step();
    Flush = 1'b1; ReqAddr = 32'h0;
    step();
    Flush = 1'b0; rv3 = 1'b0;
    chk("flushw_valid", {31'b0, val3}, 32'd0);
    chk("flushw_idle", {31'b0, rdy3}, 32'd1);
    step(); step(); step();
    chk("flushw_no_rsp", {31'b0, val3}, 32'd0);

    // flush in RESP with a request that would otherwise be accepted
    ReqAddr = 32'h0; rv1 = 1'b1;
    step();
    chk("flushr_pre", {31'b0, val1}, 32'd1);
    Flush = 1'b1; RspReady = 1'b1;
    step();
    Flush = 1'b0; rv1 = 1'b0;
    chk("flushr_valid", {31'b0, val1}, 32'd0);
    step();
    chk("flushr_no_rsp", {31'b0, val1}, 32'd0);

    // reset mid-WAIT (L3) and mid-RESP (L1)
    ReqAddr = 32'h0; rv1 = 1'b1; rv3 = 1'b1;
    step();
    rv1 = 1'b0; rv3 = 1'b0;
    chk("rstmid_l1_resp", {31'b0, val1}, 32'd1);
    chk("rstmid_l3_wait", {31'b0, rdy3}, 32'd0);
    Reset = 1'b1;
    #1;
    chk("rstmid_l1_valid", {31'b0, val1}, 32'd0);
    chk("rstmid_l1_inst", inst1, 32'h0);
    chk("rstmid_l3_idle", {31'b0, rdy3}, 32'd1);
    step();
    Reset = 1'b0;
    step(); step(); step();
    chk("rstmid_l3_no_rsp", {31'b0, val3}, 32'd0);
    rv1 = 1'b1; ReqAddr = 32'h0;
    step();
    rv1 = 1'b0;
    chk("post_rst_inst", inst1, 32'h2010_0001);
    chk("post_rst_fault", {31'b0, flt1}, 32'd0);
    step();

`ifdef INST_MEM_PARITY_EN
    LoadParityFlip = 1'b1;
    load(7'd2, 32'h0BAD_0002);
    LoadParityFlip = 1'b0;
    ReqAddr = 32'h8; rv1 = 1'b1;
    step();
    rv1 = 1'b0;
    chk("parity_fault", {31'b0, flt1}, 32'd1);
    chk("parity_inst", inst1, 32'h0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
